serializer_9to1: RTL and testbench

SERIALIZER_9TO1 -- requirements
Module: serializer_9to1

---
 rtl/serializer_9to1_pkg.sv | 27 ++
 rtl/serializer_9to1.sv | 85 ++++++++
 tb/tb_serializer_9to1.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/serializer_9to1_pkg.sv
// Shared constants, state encoding and slot-to-bit mapping for the 9-to-1 serial link.
// The receiver side reuses slot_bit so that both ends agree on the frame layout.
package serializer_9to1_pkg;

    localparam int CATCH_START_BIT_DEF = 10;
    localparam int FRAME_LEN_DEF       = 32;
    localparam int WORD_W              = 9;
    localparam int SEL_W               = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Slots catch_start..catch_start+7 carry bits 0..7; every other slot carries bit 8.
    function automatic logic slot_bit(input logic [WORD_W-1:0] word,
                                      input logic [SEL_W-1:0]  slot,
                                      input int                catch_start);
        int idx;
        idx = int'(slot) - catch_start;
        if (idx >= 0 && idx <= 7) begin
            return word[idx[2:0]];
        end
        return word[WORD_W-1];
    endfunction

endpackage

// File: rtl/serializer_9to1.sv
// 9-bit parallel to 1-bit serial framer with a one-deep holding register,
// back-to-back frame chaining and a last-slot bypass for a freshly offered word.
module serializer_9to1
    import serializer_9to1_pkg::*;
#(
    parameter int CATCH_START_BIT = CATCH_START_BIT_DEF,
    parameter int FRAME_LEN       = FRAME_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] Data_in,
    output logic              load_ready,
    output logic              Data_out,
    output logic [SEL_W-1:0]  sel,
    output logic              frame_active,
    output logic              frame_done
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(FRAME_LEN - 1);

    state_t            state;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] nxt_word;
    logic              nxt_valid;
    logic              accept;

    assign load_ready   = !nxt_valid;
    assign accept       = load_valid && load_ready;
    assign frame_active = (state == SEND);

    // NOTE: every register here, including both word registers, is cleared by reset so a
    // frame after reset can never expose stale data; all state updates are non-blocking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sel       <= '0;
            Data_out  <= 1'b0;
            frame_done <= 1'b0;
            cur_word  <= '0;
            nxt_word  <= '0;
            nxt_valid <= 1'b0;
        end else begin
            frame_done <= (state == SEND) && (sel == LAST_SEL);
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_word <= Data_in;
                        state    <= SEND;
                        sel      <= '0;
                        Data_out <= slot_bit(Data_in, '0, CATCH_START_BIT);
                    end else begin
                        sel      <= '0;
                        Data_out <= 1'b0;
                    end
                end
                SEND: begin
                    if (sel != LAST_SEL) begin
                        sel      <= sel + 1'b1;
                        Data_out <= slot_bit(cur_word, sel + 1'b1, CATCH_START_BIT);
                        if (accept) begin
                            nxt_word  <= Data_in;
                            nxt_valid <= 1'b1;
                        end
                    end else if (nxt_valid) begin
                        // Chain the held word so slot 0 follows the last slot with no gap.
                        cur_word  <= nxt_word;
                        nxt_valid <= 1'b0;
                        sel       <= '0;
                        Data_out  <= slot_bit(nxt_word, '0, CATCH_START_BIT);
                    end else if (accept) begin
                        cur_word <= Data_in;
                        sel      <= '0;
                        Data_out <= slot_bit(Data_in, '0, CATCH_START_BIT);
                    end else begin
                        state    <= IDLE;
                        sel      <= '0;
                        Data_out <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_9to1.sv
// Directed plus randomized bench for serializer_9to1 against a word-queue stream model
// and a behavioural 1-to-9 loopback receiver.
module tb_serializer_9to1;

    localparam int CSB  = 10;
    localparam int FL   = 32;
    localparam int LAST = FL - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [8:0] data_in;
    logic       load_ready;
    logic       data_out;
    logic [4:0] sel;
    logic       frame_active;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    // Stream model: words accepted but not yet started, plus the frame in flight.
    logic [8:0] q[$];
    logic [8:0] cur;
    bit         in_frame;
    int         pos;
    bit         prev_last;
    logic [8:0] rx;
    int         done_cnt;

    serializer_9to1 #(.CATCH_START_BIT(CSB), .FRAME_LEN(FL)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .Data_in     (data_in),
        .load_ready  (load_ready),
        .Data_out    (data_out),
        .sel         (sel),
        .frame_active(frame_active),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [8:0] w, input int p);
        if (p >= CSB && p < CSB + 8) return w[p - CSB];
        return w[8];
    endfunction

    task automatic model_reset();
        q.delete();
        in_frame  = 1'b0;
        pos       = 0;
        prev_last = 1'b0;
        rx        = '0;
    endtask

    // Called at the negedge of each cycle: advance the model by one edge, compare, then
    // record whether the upcoming edge accepts a word.
    task automatic model_cycle();
        logic exp_done;
        logic ready;
        exp_done = prev_last;
        if (in_frame && pos < LAST) begin
            pos++;
        end else if (q.size() > 0) begin
            cur      = q.pop_front();
            in_frame = 1'b1;
            pos      = 0;
            rx       = '0;
        end else begin
            in_frame = 1'b0;
            pos      = 0;
        end
        prev_last = in_frame && (pos == LAST);
        ready     = (q.size() == 0);

        check("frame_active", {8'd0, frame_active}, {8'd0, in_frame});
        check("sel", {4'd0, sel}, in_frame ? 9'(pos) : 9'd0);
        check("data_out", {8'd0, data_out}, {8'd0, in_frame ? exp_bit(cur, pos) : 1'b0});
        check("frame_done", {8'd0, frame_done}, {8'd0, exp_done});
        check("load_ready", {8'd0, load_ready}, {8'd0, ready});
        if (frame_done === 1'b1) done_cnt++;

        if (in_frame) begin
            if (pos >= CSB && pos < CSB + 8) rx[pos - CSB] = data_out;
            if (pos == 0) rx[8] = data_out;
            if (pos == LAST) check("loopback_word", rx, cur);
        end

        if (load_valid && ready) q.push_back(data_in);
    endtask

    task automatic step(input logic lv, input logic [8:0] d);
        load_valid = lv;
        data_in    = d;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        load_valid = 1'b0;
        data_in    = '0;
        done_cnt   = 0;
        model_reset();

        // Reset values
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst_sel", {4'd0, sel}, 9'd0);
        check("rst_data_out", {8'd0, data_out}, 9'd0);
        check("rst_frame_done", {8'd0, frame_done}, 9'd0);
        check("rst_frame_active", {8'd0, frame_active}, 9'd0);
        check("rst_load_ready", {8'd0, load_ready}, 9'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single word
        base = done_cnt;
        step(1'b1, 9'h1A5);
        repeat (36) step(1'b0, '0);
        check("single_done_count", 9'(done_cnt - base), 9'd1);
        check("single_idle", {8'd0, frame_active}, 9'd0);

        // Back-to-back frames
        base = done_cnt;
        step(1'b1, 9'h0FF);
        repeat (5) step(1'b0, '0);
        step(1'b1, 9'h100);
        repeat (65) step(1'b0, '0);
        check("b2b_done_count", 9'(done_cnt - base), 9'd2);

        // Backpressure: hold load_valid with changing data
        for (int i = 0; i < 110; i++) step(1'b1, 9'($urandom));
        repeat (70) step(1'b0, '0);
        check("bp_drained", 9'(q.size()), 9'd0);

        // Last-slot bypass
        step(1'b1, 9'h1C3);
        repeat (31) step(1'b0, '0);
        step(1'b1, 9'h055);
        load_valid = 1'b0;
        @(negedge clk);
        check("bypass_sel", {4'd0, sel}, 9'd0);
        check("bypass_bit", {8'd0, data_out}, 9'd0);
        check("bypass_active", {8'd0, frame_active}, 9'd1);
        model_cycle();
        @(posedge clk);
        #1;
        repeat (35) step(1'b0, '0);

        // Reset mid-frame with a pending word
        base = done_cnt;
        step(1'b1, 9'h0AA);
        step(1'b1, 9'h133);
        repeat (13) step(1'b0, '0);
        load_valid = 1'b0;
        @(negedge clk);
        model_cycle();
        check("pre_rst_sel14", {4'd0, sel}, 9'd14);
        #2 reset = 1'b0;
        #1;
        check("midrst_sel", {4'd0, sel}, 9'd0);
        check("midrst_data_out", {8'd0, data_out}, 9'd0);
        check("midrst_load_ready", {8'd0, load_ready}, 9'd1);
        check("midrst_active", {8'd0, frame_active}, 9'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (40) step(1'b0, '0);
        check("midrst_no_done", 9'(done_cnt - base), 9'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) step($urandom_range(0, 3) == 0, 9'($urandom));
        repeat (70) step(1'b0, '0);
        check("final_idle", {8'd0, frame_active}, 9'd0);
        check("final_queue_empty", 9'(q.size()), 9'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
